// File: rtl/demux2_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux2_stream
// Purpose  : Registered 1-to-2 stream demultiplexer. Each input word is
//            steered to lane 0 or lane 1 by in_sel. Every lane has its own
//            1-entry valid/ready output buffer, so a stalled lane never blocks
//            the other. Each lane also counts the words it has delivered.
// Ports    : clk                  rising-edge clock
//            reset                synchronous, active-high reset
//            in_valid/in_ready    input handshake
//            in_data [W]          input word
//            in_sel               destination lane (0 = lane 0, 1 = lane 1)
//            outK_valid/outK_ready  lane K output handshake (K = 0, 1)
//            outK_data [W]        lane K word
//            cntK [CNT_W]         lane K delivered-word counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module demux2_stream #(
  parameter int W     = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [W-1:0]     out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [W-1:0]     out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam int N_LANES = 2;

  // Per-lane state; index 0 is lane 0, index 1 is lane 1.
  logic [N_LANES-1:0]            valid_q, valid_d;
  logic [N_LANES-1:0][W-1:0]     data_q,  data_d;
  logic [N_LANES-1:0][CNT_W-1:0] cnt_q,   cnt_d;

  logic [N_LANES-1:0] lane_ready;
  logic [N_LANES-1:0] lane_accept;
  logic [N_LANES-1:0] lane_hs;
  logic               accept;

  assign lane_ready = {out1_ready, out0_ready};

  // Only the addressed lane gates the input: a full, stalled lane blocks only
  // the words that are headed for it. A full lane that is being drained this
  // cycle can take a new word at the same edge.
  assign in_ready    = ~reset & (~valid_q[in_sel] | lane_ready[in_sel]);
  assign accept      = in_valid & in_ready;
  assign lane_accept = {accept & in_sel, accept & ~in_sel};
  assign lane_hs     = valid_q & lane_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    for (int k = 0; k < N_LANES; k++) begin
      // An accept wins over a drain: the new word replaces the one leaving.
      if (lane_accept[k]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end else if (lane_hs[k]) begin
        valid_d[k] = 1'b0;
      end
      if (lane_hs[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out0_valid = valid_q[0];
  assign out0_data  = data_q[0];
  assign cnt0       = cnt_q[0];
  assign out1_valid = valid_q[1];
  assign out1_data  = data_q[1];
  assign cnt1       = cnt_q[1];

endmodule
`default_nettype wire

// File: tb/tb_demux2_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux2_stream
// Purpose  : Self-checking bench for demux2_stream (CNT_W = 2 so counter
//            wrap is reachable). The driver pushes each word it expects to be
//            accepted into a per-lane queue; a monitor on the falling edge
//            checks valid, data and counter of both lanes against that model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux2_stream;

  localparam int W     = 2;
  localparam int CNT_W = 2;

  logic             clk        = 1'b0;
  logic             reset      = 1'b1;
  logic             in_valid   = 1'b0;
  logic             in_sel     = 1'b0;
  logic [W-1:0]     in_data    = '0;
  logic             out0_ready = 1'b0;
  logic             out1_ready = 1'b0;
  logic             in_ready;
  logic             out0_valid, out1_valid;
  logic [W-1:0]     out0_data,  out1_data;
  logic [CNT_W-1:0] cnt0, cnt1;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]     exp_q0[$];
  logic [W-1:0]     exp_q1[$];
  logic [W-1:0]     last_exp[2];
  logic [CNT_W-1:0] cnt_exp[2];
  bit               mon_en = 1'b0;

  demux2_stream #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One lane of the monitor: model valid = queue non-empty, model handshake =
  // model valid & ready.
  task automatic mon_lane(input int k, input logic v, input logic rdy,
                          input logic [W-1:0] d, input logic [CNT_W-1:0] c);
    int           depth;
    logic [W-1:0] front;
    depth = (k == 0) ? exp_q0.size() : exp_q1.size();
    chk($sformatf("lane%0d_valid", k), 32'(v), 32'(depth != 0));
    chk($sformatf("lane%0d_cnt", k), 32'(c), 32'(cnt_exp[k]));
    if (depth != 0) begin
      front = (k == 0) ? exp_q0[0] : exp_q1[0];
      chk($sformatf("lane%0d_data", k), 32'(d), 32'(front));
      if (rdy) begin
        if (k == 0) void'(exp_q0.pop_front());
        else        void'(exp_q1.pop_front());
        cnt_exp[k] = cnt_exp[k] + 1'b1;
      end
    end else begin
      chk($sformatf("lane%0d_hold", k), 32'(d), 32'(last_exp[k]));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      mon_lane(0, out0_valid, out0_ready, out0_data, cnt0);
      mon_lane(1, out1_valid, out1_ready, out1_data, cnt1);
    end
  end

  // One clock cycle of stimulus, entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic v, input logic s, input logic [W-1:0] d,
                       input logic exp_rdy, input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (v && exp_rdy) begin
      if (s) exp_q1.push_back(d);
      else   exp_q0.push_back(d);
      last_exp[s] = d;
    end
  endtask

  // One reset cycle with a live transfer presented; nothing may be taken.
  task automatic do_reset();
    reset      = 1'b1;
    in_valid   = 1'b1;
    in_sel     = 1'b1;
    in_data    = 2'b10;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_in_reset", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    last_exp = '{default: '0};
    cnt_exp  = '{default: '0};
    mon_en   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CNT_W-1:0] wrap_seq[5];
    wrap_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    last_exp = '{default: '0};
    cnt_exp  = '{default: '0};

    @(posedge clk);
    #1;
    do_reset();

    // 1: every data x sel, both lanes draining, one word per cycle.
    for (int s = 0; s < 2; s++) begin
      for (int d = 0; d < 4; d++) begin
        cycle(1'b1, 1'(s), 2'(d), 1'b1, 1'b1, 1'b1);
      end
    end
    cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);

    // 2: backpressure on lane 0, then drain + reload at the same edge.
    cycle(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
    chk("t2_held_data",  32'(out0_data),  32'h1);
    chk("t2_held_valid", 32'(out0_valid), 32'h1);
    cycle(1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1);
    chk("t2_reload_valid", 32'(out0_valid), 32'h1);
    chk("t2_reload_data",  32'(out0_data),  32'h2);

    // 3: lane 0 stalled and full, lane 1 still accepts.
    cycle(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    chk("t3_out1_data",  32'(out1_data),  32'h3);
    chk("t3_out1_valid", 32'(out1_valid), 32'h1);
    chk("t3_out0_data",  32'(out0_data),  32'h2);
    chk("t3_out0_valid", 32'(out0_valid), 32'h1);
    cycle(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);

    // 4: both lanes full, both drain, lane 1 reloads.
    chk("t4_cnt0_before", 32'(cnt0), 32'h1);
    chk("t4_cnt1_before", 32'(cnt1), 32'h0);
    cycle(1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1);
    chk("t4_cnt0_after",  32'(cnt0),       32'h2);
    chk("t4_cnt1_after",  32'(cnt1),       32'h1);
    chk("t4_out0_valid",  32'(out0_valid), 32'h0);
    chk("t4_out0_kept",   32'(out0_data),  32'h2);
    chk("t4_out1_valid",  32'(out1_valid), 32'h1);
    chk("t4_out1_data",   32'(out1_data),  32'h1);
    cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);

    // 5: counter wrap on lane 1.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 2'(i), 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
      chk($sformatf("t5_cnt1_%0d", i), 32'(cnt1), 32'(wrap_seq[i]));
      chk($sformatf("t5_cnt0_%0d", i), 32'(cnt0), 32'h0);
    end

    // 6: reset while lane 0 is full with cnt0 = 3.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 2'(i + 1), 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
    end
    cycle(1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
    chk("t6_cnt0_before",  32'(cnt0),       32'h3);
    chk("t6_valid_before", 32'(out0_valid), 32'h1);
    do_reset();
    chk("t6_out0_valid", 32'(out0_valid), 32'h0);
    chk("t6_out0_data",  32'(out0_data),  32'h0);
    chk("t6_cnt0",       32'(cnt0),       32'h0);
    chk("t6_out1_valid", 32'(out1_valid), 32'h0);
    chk("t6_cnt1",       32'(cnt1),       32'h0);
    cycle(1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
    chk("t6_resume_valid", 32'(out0_valid), 32'h1);
    chk("t6_resume_data",  32'(out0_data),  32'h2);
    cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
